paddle_ctrl: RTL
================

Name: paddle_ctrl

Overview:
- Downstream consumer of the UART key decoder. Turns single-cycle up/down key pulses, produced from received 'W'/'S' bytes, into paddle vertical position for the game renderer.
- UART keyboard input gives repeated characters, not held levels, so each pulse starts a fixed-length movement burst: one step per frame tick for HOLD_TICKS ticks.
- Position is clamped to the playfield.

Parameters:
- Y_WIDTH, 10, width of the position bus.
- SCREEN_H, 480, playfield height in pixels.
- PADDLE_H, 80, paddle height in pixels. Maximum y = SCREEN_H - PADDLE_H = 400.
- STEP, 4, pixels moved per frame tick.
- HOLD_TICKS, 8, frame ticks of movement per accepted key pulse. Must be ≥ 1.
- INIT_Y, 200, position after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- key_up  in  1  one-cycle pulse, synchronous to clk: move-up request.
- key_down  in  1  one-cycle pulse, synchronous to clk: move-down request.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- paddle_y  out  Y_WIDTH  top edge of the paddle, in pixels, from 0 to SCREEN_H-PADDLE_H.
- moving_up  out  1  high while in state MOVE_UP.
- moving_down  out  1  high while in state MOVE_DOWN.
- at_top  out  1  high when paddle_y == 0.
- at_bottom  out  1  high when paddle_y == SCREEN_H-PADDLE_H.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: paddle_y=INIT_Y, state=IDLE, hold_cnt=0, moving_up=0, moving_down=0. at_top and at_bottom follow from INIT_Y.
- Reset mid-burst aborts the burst immediately.
- Registers: state (IDLE, MOVE_UP, MOVE_DOWN), hold_cnt (sized to hold HOLD_TICKS), paddle_y.
- Outputs: all registered, or decoded directly from registers; no combinational path from the inputs.
- Key pulse handling, checked before tick handling on every edge:
  - key_up=1 and key_down=0: state becomes MOVE_UP and hold_cnt loads HOLD_TICKS. This applies from any state, so a same-direction pulse re-arms the burst and an opposite-direction pulse reverses it at once.
  - key_down=1 and key_up=0: same rule, state becomes MOVE_DOWN.
  - key_up=1 and key_down=1 together: both are ignored. State, hold_cnt and paddle_y are unchanged by the keys; the tick rule below still applies.
  - If a valid pulse arrives on the same edge as frame_tick, the pulse wins: it loads the state and counter, and paddle_y does not change on that edge. Movement begins on the next frame_tick.
- Tick handling (frame_tick=1, no valid pulse):
  - IDLE: no change.
  - MOVE_UP: if paddle_y ≤ STEP, paddle_y becomes 0; otherwise paddle_y becomes paddle_y - STEP.
  - MOVE_DOWN: if paddle_y + STEP ≥ SCREEN_H-PADDLE_H, paddle_y becomes SCREEN_H-PADDLE_H; otherwise paddle_y becomes paddle_y + STEP.
  - Arithmetic is done at Y_WIDTH+1 bits, so there is no wrap-around.
  - After the move, hold_cnt decrements. If the new hold_cnt is 0, or the move reached a limit (0 or max), state goes to IDLE and hold_cnt is cleared on the same edge.
- Burst length: an isolated pulse yields exactly HOLD_TICKS moves unless a limit is hit first.
- Latency: paddle_y reflects a tick's move on the cycle after the frame_tick edge.
- Key pulse at a limit: a key_up pulse when at_top=1 (or key_down when at_bottom=1) enters the MOVE state. The next tick clamps, position is unchanged, and the state returns to IDLE.
- frame_tick held high for several cycles: each high cycle counts as one tick. The block does not detect edges.

Test Plan:
1. Reset, key_up pulse, then 8 frame_ticks spaced 10 cycles apart → paddle_y goes 196, 192, … 168. moving_up is high for the whole burst and drops on the 8th tick edge. A 9th tick leaves paddle_y at 168.
2. Top clamp: with paddle_y=8, key_up, then ticks → 4, then 0; at_top=1 and state is IDLE after the second tick. Further ticks cause no change. Mirror case: from 396, key_down, one tick → 400, at_bottom=1, IDLE.
3. Re-arm and reverse:
   - From 200: key_up, 3 ticks → 188. Second key_up, 8 ticks → 156, then IDLE.
   - Reverse: from 200, key_up, 2 ticks → 192. key_down, 8 ticks → 224.
4. Simultaneous events:
   - key_up and key_down in the same cycle while IDLE → no state change; ticks leave y=200.
   - key_up coincident with frame_tick → y unchanged on that edge; the first move comes on the next tick.
5. Reset mid-operation: during a MOVE_DOWN burst at y=212, assert rst for 1 cycle → y=200, moving_down=0. Following ticks cause no change.

Source files
------------

// File: rtl/paddle_ctrl.sv
// paddle_ctrl
//   Turns single-cycle up/down key pulses into a paddle vertical position.
//   The keys come from a UART decoder, so they are repeated characters
//   rather than held levels. Each accepted pulse therefore starts a burst of
//   HOLD_TICKS moves, one STEP per frame tick, clamped to the playfield.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   key_up       one-cycle move-up request
//   key_down     one-cycle move-down request
//   frame_tick   one pulse per video frame; every high cycle counts as a tick
//   paddle_y     top edge of the paddle, 0 .. SCREEN_H-PADDLE_H
//   moving_up    high while a move-up burst is active
//   moving_down  high while a move-down burst is active
//   at_top       paddle_y == 0
//   at_bottom    paddle_y == SCREEN_H-PADDLE_H
module paddle_ctrl #(
    parameter int Y_WIDTH    = 10,
    parameter int SCREEN_H   = 480,
    parameter int PADDLE_H   = 80,
    parameter int STEP       = 4,
    parameter int HOLD_TICKS = 8,
    parameter int INIT_Y     = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               frame_tick,
    output logic [Y_WIDTH-1:0] paddle_y,
    output logic               moving_up,
    output logic               moving_down,
    output logic               at_top,
    output logic               at_bottom
);

    localparam int CNT_W = $clog2(HOLD_TICKS + 1);

    // Position arithmetic uses one extra bit so y + STEP cannot wrap.
    localparam logic [Y_WIDTH:0]   STEP_X    = (Y_WIDTH + 1)'(STEP);
    localparam logic [Y_WIDTH:0]   Y_MAX_X   = (Y_WIDTH + 1)'(SCREEN_H - PADDLE_H);
    localparam logic [Y_WIDTH-1:0] Y_MAX     = Y_WIDTH'(SCREEN_H - PADDLE_H);
    localparam logic [Y_WIDTH-1:0] Y_INIT    = Y_WIDTH'(INIT_Y);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;

    // True when an upward step saturates at the top edge.
    function automatic logic up_hits_limit(input logic [Y_WIDTH-1:0] y);
        return ({1'b0, y} <= STEP_X);
    endfunction

    // Upward step saturated at 0.
    function automatic logic [Y_WIDTH-1:0] step_up(input logic [Y_WIDTH-1:0] y);
        logic [Y_WIDTH:0] diff;
        diff = {1'b0, y} - STEP_X;
        if (up_hits_limit(y))
            return '0;
        return diff[Y_WIDTH-1:0];
    endfunction

    // True when a downward step saturates at the bottom edge.
    function automatic logic down_hits_limit(input logic [Y_WIDTH-1:0] y);
        return (({1'b0, y} + STEP_X) >= Y_MAX_X);
    endfunction

    // Downward step saturated at SCREEN_H-PADDLE_H.
    function automatic logic [Y_WIDTH-1:0] step_down(input logic [Y_WIDTH-1:0] y);
        logic [Y_WIDTH:0] sum;
        sum = {1'b0, y} + STEP_X;
        if (down_hits_limit(y))
            return Y_MAX;
        return sum[Y_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            paddle_y    <= Y_INIT;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
        end else if (key_up ^ key_down) begin
            // A valid pulse always (re)arms the burst and takes priority
            // over a coincident tick, so no move happens on this edge.
            hold_cnt <= HOLD_LOAD;
            if (key_up) begin
                state       <= MOVE_UP;
                moving_up   <= 1'b1;
                moving_down <= 1'b0;
            end else begin
                state       <= MOVE_DOWN;
                moving_up   <= 1'b0;
                moving_down <= 1'b1;
            end
        end else if (frame_tick) begin
            case (state)
                MOVE_UP: begin
                    paddle_y <= step_up(paddle_y);
                    // hold_cnt is at least 1 in a MOVE state, so ==1 means
                    // this tick consumes the last move of the burst.
                    if (hold_cnt == CNT_ONE || up_hits_limit(paddle_y)) begin
                        state     <= IDLE;
                        hold_cnt  <= '0;
                        moving_up <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_ONE;
                    end
                end
                MOVE_DOWN: begin
                    paddle_y <= step_down(paddle_y);
                    if (hold_cnt == CNT_ONE || down_hits_limit(paddle_y)) begin
                        state       <= IDLE;
                        hold_cnt    <= '0;
                        moving_down <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign at_top    = (paddle_y == '0);
    assign at_bottom = (paddle_y == Y_MAX);

endmodule
